// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: register-index width, memory-wait FSM encoding,
// EX forwarding-mux select codes and the source/destination match helper.
package hazard_stall_unit_pkg;

    localparam int REG_IDX_W = 4;

    // Forwarding-select codes used by the EX operand mux.
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    // True when a writing stage targets one of the registers the ID instruction reads.
    function automatic logic src_match(
        input logic                 wb_en,
        input logic [REG_IDX_W-1:0] dest,
        input logic [REG_IDX_W-1:0] rn,
        input logic [REG_IDX_W-1:0] rm,
        input logic                 two_src
    );
        return wb_en && ((rn == dest) || (two_src && (rm == dest)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle of pipeline-state inputs and stall/freeze/flush controls for the hazard unit.
//
// Memory handshake: mem_req is held high by the MEM stage for the whole access;
// the access completes in the cycle where mem_req and mem_ready are both high.
// mem_ready in the request cycle means a zero-wait access. Dropping mem_req
// before mem_ready is a protocol violation and is treated as completion.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    import hazard_stall_unit_pkg::*;

    logic [REG_IDX_W-1:0] Rn_src;
    logic [REG_IDX_W-1:0] Rm_src;
    logic                 Two_src;
    logic                 ID_valid;
    logic [REG_IDX_W-1:0] EX_Dest;
    logic                 EX_WB_EN;
    logic                 EX_MEM_R_EN;
    logic [REG_IDX_W-1:0] MEM_Dest;
    logic                 MEM_WB_EN;
    logic                 operation_mode;
    logic                 branch_taken;
    logic                 mem_req;
    logic                 mem_ready;

    logic                 hazard;
    logic                 freeze;
    logic                 flush;
    logic                 mem_timeout;
    logic [CNT_W-1:0]     load_stall_cnt;
    logic [CNT_W-1:0]     mem_stall_cnt;
    mem_state_t           state_dbg;

    // Pipeline side: drives stage information, consumes the controls.
    modport master (
        output Rn_src, Rm_src, Two_src, ID_valid, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
               MEM_Dest, MEM_WB_EN, operation_mode, branch_taken, mem_req, mem_ready,
        input  hazard, freeze, flush, mem_timeout, load_stall_cnt, mem_stall_cnt, state_dbg
    );

    // Hazard unit side.
    modport slave (
        input  Rn_src, Rm_src, Two_src, ID_valid, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
               MEM_Dest, MEM_WB_EN, operation_mode, branch_taken, mem_req, mem_ready,
        output hazard, freeze, flush, mem_timeout, load_stall_cnt, mem_stall_cnt, state_dbg
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count enabled cycles, stopping at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard unit: load-use / no-forwarding RAW stalls, data-memory wait
// freeze with sticky timeout, taken-branch flush, and stall statistics.
module hazard_stall_unit #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_unit_if.slave bus
);
    import hazard_stall_unit_pkg::*;

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic              match_ex;
    logic              match_mem;
    logic              raw_hazard;
    logic              freeze_c;
    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              timeout_q;
    logic              timeout_nxt;

    // RAW detection: with forwarding only an EX load must stall, otherwise any
    // pending write in EX or MEM does.
    always_comb begin
        match_ex   = src_match(bus.EX_WB_EN, bus.EX_Dest, bus.Rn_src, bus.Rm_src, bus.Two_src);
        match_mem  = src_match(bus.MEM_WB_EN, bus.MEM_Dest, bus.Rn_src, bus.Rm_src, bus.Two_src);
        raw_hazard = bus.ID_valid &&
                     (bus.operation_mode ? (match_ex && bus.EX_MEM_R_EN)
                                         : (match_ex || match_mem));
    end

    // Memory-wait FSM next state, wait counter and freeze decode.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = timeout_q;
        freeze_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    freeze_c     = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            WAIT: begin
                freeze_c = !bus.mem_ready;
                if (bus.mem_ready || !bus.mem_req) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    state_nxt   = ERR;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ERR: begin
                freeze_c = 1'b1;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Control outputs: freeze overrides both flush and the hazard stall.
    always_comb begin
        bus.freeze      = freeze_c;
        bus.hazard      = raw_hazard && !freeze_c;
        bus.flush       = bus.branch_taken && !freeze_c;
        bus.mem_timeout = timeout_q;
        bus.state_dbg   = state;
    end

    sat_counter #(.W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.hazard),
        .count (bus.load_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.freeze),
        .count (bus.mem_stall_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle by a behavioural model.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    localparam int CNT_W    = 3;
    localparam int MAX_WAIT = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] exp_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    // m_waited: cycles already spent waiting on the current access (0 = none).
    bit   model_on = 1'b0;
    int   m_waited;
    bit   m_err;
    int   m_lcnt;
    int   m_mcnt;
    bit   m_mex, m_mmem, m_raw, m_frz, m_hz, m_fl;
    logic [1:0] m_st;
    logic [5:0] m_exp;

    always @(negedge clk) begin
        if (model_on) begin
            m_mex  = bus.EX_WB_EN && (bus.Rn_src == bus.EX_Dest || (bus.Two_src && bus.Rm_src == bus.EX_Dest));
            m_mmem = bus.MEM_WB_EN && (bus.Rn_src == bus.MEM_Dest || (bus.Two_src && bus.Rm_src == bus.MEM_Dest));
            if (!bus.ID_valid) m_raw = 1'b0;
            else if (bus.operation_mode) m_raw = m_mex && bus.EX_MEM_R_EN;
            else m_raw = m_mex || m_mmem;
            m_frz = m_err || (!bus.mem_ready && (m_waited > 0 || bus.mem_req));
            m_hz  = m_raw && !m_frz;
            m_fl  = bus.branch_taken && !m_frz;
            m_st  = m_err ? 2'd2 : (m_waited > 0 ? 2'd1 : 2'd0);
            exp_q.push_back({m_hz, m_frz, m_fl, m_err, m_st});

            m_exp = exp_q.pop_front();
            check("m_hazard",  bus.hazard,         m_exp[5]);
            check("m_freeze",  bus.freeze,         m_exp[4]);
            check("m_flush",   bus.flush,          m_exp[3]);
            check("m_timeout", bus.mem_timeout,    m_exp[2]);
            check("m_state",   bus.state_dbg,      m_exp[1:0]);
            check("m_lcnt",    bus.load_stall_cnt, m_lcnt);
            check("m_mcnt",    bus.mem_stall_cnt,  m_mcnt);

            // Advance to the state after the coming rising edge.
            if (rst) begin
                m_waited = 0; m_err = 0; m_lcnt = 0; m_mcnt = 0;
            end else begin
                if (m_hz  && m_lcnt < CNT_MAX) m_lcnt++;
                if (m_frz && m_mcnt < CNT_MAX) m_mcnt++;
                if (!m_err) begin
                    if (m_waited > 0) begin
                        if (bus.mem_ready || !bus.mem_req) m_waited = 0;
                        else if (m_waited == MAX_WAIT) m_err = 1'b1;
                        else m_waited++;
                    end else if (bus.mem_req && !bus.mem_ready) begin
                        m_waited = 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Rn_src = '0; bus.Rm_src = '0; bus.Two_src = 1'b0; bus.ID_valid = 1'b0;
        bus.EX_Dest = '0; bus.EX_WB_EN = 1'b0; bus.EX_MEM_R_EN = 1'b0;
        bus.MEM_Dest = '0; bus.MEM_WB_EN = 1'b0; bus.operation_mode = 1'b0;
        bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    task automatic random_inputs();
        rst                = ($urandom_range(0, 59) == 0);
        bus.Rn_src         = 4'($urandom_range(0, 3));
        bus.Rm_src         = 4'($urandom_range(0, 3));
        bus.Two_src        = 1'($urandom_range(0, 1));
        bus.ID_valid       = ($urandom_range(0, 3) != 0);
        bus.EX_Dest        = 4'($urandom_range(0, 3));
        bus.EX_WB_EN       = 1'($urandom_range(0, 1));
        bus.EX_MEM_R_EN    = 1'($urandom_range(0, 1));
        bus.MEM_Dest       = 4'($urandom_range(0, 3));
        bus.MEM_WB_EN      = 1'($urandom_range(0, 1));
        bus.operation_mode = 1'($urandom_range(0, 1));
        bus.branch_taken   = ($urandom_range(0, 3) == 0);
        bus.mem_req        = ($urandom_range(0, 3) != 0);
        bus.mem_ready      = ($urandom_range(0, 2) != 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        m_waited = 0; m_err = 0; m_lcnt = 0; m_mcnt = 0;
        rst = 1'b1;
        next();
        model_on = 1'b1;
        next();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_hazard",  bus.hazard, 0);
        check("rst_freeze",  bus.freeze, 0);
        check("rst_flush",   bus.flush, 0);
        check("rst_timeout", bus.mem_timeout, 0);
        check("rst_lcnt",    bus.load_stall_cnt, 0);
        check("rst_mcnt",    bus.mem_stall_cnt, 0);
        next();

        // Load-use with forwarding on: one stall cycle, then the load has moved on.
        bus.operation_mode = 1'b1; bus.EX_Dest = 4'd3; bus.EX_WB_EN = 1'b1;
        bus.EX_MEM_R_EN = 1'b1; bus.ID_valid = 1'b1; bus.Rn_src = 4'd3;
        @(negedge clk); check("lu_hazard", bus.hazard, 1);
        next();
        bus.EX_MEM_R_EN = 1'b0;
        @(negedge clk); check("lu_noload_hazard", bus.hazard, 0);
        check("lu_lcnt", bus.load_stall_cnt, 1);
        next();

        // Forwarding off: MEM-stage writer matched through Rm.
        bus.operation_mode = 1'b0; bus.EX_WB_EN = 1'b0; bus.MEM_WB_EN = 1'b1;
        bus.MEM_Dest = 4'd5; bus.Rm_src = 4'd5; bus.Two_src = 1'b1; bus.Rn_src = 4'd0;
        @(negedge clk); check("nf_rm_hazard", bus.hazard, 1);
        next();
        bus.Two_src = 1'b0;
        @(negedge clk); check("nf_one_src_hazard", bus.hazard, 0);
        next();
        bus.Two_src = 1'b1; bus.ID_valid = 1'b0;
        @(negedge clk); check("nf_invalid_hazard", bus.hazard, 0);
        next();

        // Three-cycle memory wait with a concurrent RAW hazard and a taken branch.
        do_reset();
        bus.mem_req = 1'b1; bus.ID_valid = 1'b1; bus.MEM_WB_EN = 1'b1;
        bus.MEM_Dest = 4'd5; bus.Rn_src = 4'd5; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mw_freeze", bus.freeze, 1);
            check("mw_hazard", bus.hazard, 0);
            check("mw_flush",  bus.flush, 0);
            next();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("mw_done_freeze", bus.freeze, 0);
        check("mw_done_flush",  bus.flush, 1);
        check("mw_done_hazard", bus.hazard, 1);
        next();
        idle_inputs();
        @(negedge clk);
        check("mw_mcnt",  bus.mem_stall_cnt, 3);
        check("mw_lcnt",  bus.load_stall_cnt, 1);
        check("mw_state", bus.state_dbg, IDLE);
        next();

        // Taken branch while idle flushes immediately.
        bus.branch_taken = 1'b1;
        @(negedge clk); check("br_idle_flush", bus.flush, 1);
        next();
        bus.branch_taken = 1'b0;

        // Timeout: ready never arrives.
        bus.mem_req = 1'b1;
        for (int i = 0; i <= MAX_WAIT; i++) begin
            @(negedge clk);
            check("to_freeze", bus.freeze, 1);
            check("to_not_yet", bus.mem_timeout, 0);
            next();
        end
        @(negedge clk);
        check("to_timeout", bus.mem_timeout, 1);
        check("to_state",   bus.state_dbg, ERR);
        check("to_mcnt_sat", bus.mem_stall_cnt, CNT_MAX);
        next();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("err_freeze",  bus.freeze, 1);
            check("err_timeout", bus.mem_timeout, 1);
            next();
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk); check("err_rst_cycle_freeze", bus.freeze, 1);
        next();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_freeze",  bus.freeze, 0);
        check("post_rst_timeout", bus.mem_timeout, 0);
        check("post_rst_mcnt",    bus.mem_stall_cnt, 0);
        check("post_rst_state",   bus.state_dbg, IDLE);
        next();

        // Hazard held ten cycles saturates the load-stall counter.
        bus.operation_mode = 1'b1; bus.EX_Dest = 4'd3; bus.EX_WB_EN = 1'b1;
        bus.EX_MEM_R_EN = 1'b1; bus.ID_valid = 1'b1; bus.Rn_src = 4'd3;
        repeat (10) next();
        bus.ID_valid = 1'b0;
        @(negedge clk); check("sat_lcnt", bus.load_stall_cnt, CNT_MAX);
        next();

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            next();
        end
        idle_inputs();
        rst = 1'b0;
        next();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Companion to the EX-stage forwarding logic in the 5-stage ARM pipeline; sits between the ID/EX and EX/MEM boundaries.
- Resolves the dependencies that forwarding cannot cover:
  - load-use hazards;
  - all RAW hazards when forwarding is disabled;
  - multi-cycle data-memory waits;
  - taken-branch flushes.
- Drives stall, freeze and flush controls to the pipeline registers.
- Keeps saturating stall counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of each saturating stall counter.
- MAX_WAIT, 64, memory-wait cycles after which mem_timeout is set (must be ≥ 1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset. One clock; all state updates on rising clk.
- Rn_src  in  4  ID-stage first source register.
- Rm_src  in  4  ID-stage second source register.
- Two_src  in  1  ID instruction reads Rm_src.
- ID_valid  in  1  ID holds a real instruction.
- EX_Dest  in  4  EX-stage destination.
- EX_WB_EN  in  1  EX instruction writes back.
- EX_MEM_R_EN  in  1  EX instruction is a load.
- MEM_Dest  in  4  MEM-stage destination.
- MEM_WB_EN  in  1  MEM instruction writes back.
- operation_mode  in  1  1 = forwarding enabled.
- branch_taken  in  1  EX resolves a taken branch.
- mem_req  in  1  MEM stage issues a data-memory access.
- mem_ready  in  1  memory completes the access this cycle.
- hazard  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- freeze  out  1  hold every pipeline register.
- flush  out  1  clear IF/ID and ID/EX.
- mem_timeout  out  1  sticky wait-timeout error.
- load_stall_cnt  out  CNT_W  cycles with hazard asserted.
- mem_stall_cnt  out  CNT_W  cycles with freeze asserted.

Behaviour:

Reset and outputs:
- Reset values: hazard=0, freeze=0, flush=0, mem_timeout=0, both counters=0, FSM=IDLE, wait counter=0.
- hazard, freeze and flush are combinational from the current inputs and FSM state, with zero-cycle latency.

Hazard conditions:
- match_ex = EX_WB_EN && (Rn_src==EX_Dest || (Two_src && Rm_src==EX_Dest)).
- match_mem = the same expression using MEM_WB_EN and MEM_Dest.
- raw_hazard = ID_valid && (operation_mode ? (match_ex && EX_MEM_R_EN) : (match_ex || match_mem)).

Memory-wait FSM (states IDLE, WAIT, ERR):
- IDLE:
  - mem_req && !mem_ready → WAIT, wait counter=1.
  - Otherwise stay in IDLE.
- WAIT:
  - mem_ready → IDLE, wait counter=0.
  - Else if wait counter == MAX_WAIT → ERR, mem_timeout=1.
  - Else wait counter increments.
  - mem_req deasserting while in WAIT is a protocol violation; treat it as completion and return to IDLE.
- ERR:
  - freeze stays 1 and mem_timeout stays 1 until rst.
  - mem_ready has no effect.

Output equations:
- freeze = (state==IDLE && mem_req && !mem_ready) || (state==WAIT && !mem_ready) || state==ERR.
- hazard = raw_hazard && !freeze.
- flush = branch_taken && !freeze.

Priority and corner cases:
- Priority is freeze > flush > hazard for pipeline action. hazard and flush may both be 1; the pipeline applies flush, and the hazard stall is harmless because the bubble is cleared anyway.
- An access with mem_ready=1 in the same cycle as mem_req completes in zero wait cycles: no freeze, no state change.

Counters:
- load_stall_cnt increments in each cycle where hazard=1.
- mem_stall_cnt increments in each cycle where freeze=1.
- Both saturate at all-ones and never wrap.

Reset mid-operation:
- rst in WAIT or ERR returns the FSM to IDLE and clears all state on the next edge.
- Outputs during the rst cycle are still computed from the pre-reset state.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2);
  - the 4-bit register-index width constant;
  - the SEL_* forwarding-select constants already used by the EX mux (00 none, 01 MEM, 10 WB).
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice.

Test Plan:
- operation_mode=1, EX load EX_Dest=3, EX_MEM_R_EN=1, EX_WB_EN=1, ID Rn_src=3 → hazard=1 for exactly one cycle, load_stall_cnt=1. Same case with EX_MEM_R_EN=0 → hazard=0.
- operation_mode=0, MEM_WB_EN=1, MEM_Dest=5, Rm_src=5, Two_src=1 → hazard=1. Same case with Two_src=0 → hazard=0. ID_valid=0 → hazard=0 in all cases.
- mem_req=1, mem_ready low for 3 cycles then high → freeze=1 for 3 cycles then 0, FSM back to IDLE, mem_stall_cnt=3. A concurrent raw_hazard during the wait gives hazard=0.
- MAX_WAIT=4, mem_ready held low → freeze stays 1, mem_timeout=1 after cycle 4 and stays set. Asserting rst → all outputs 0 on the next cycle.
- branch_taken=1 while idle → flush=1 the same cycle. branch_taken=1 during WAIT → flush=0; flush asserts in the first unfrozen cycle if branch_taken is still high.
- CNT_W=3, hazard held for 10 cycles → load_stall_cnt saturates at 7.
